// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Serial-in, parallel-out word assembler. Samples one serial bit on each
//   rising clock edge where i_enable is high, packs Width bits into a word and
//   presents it with a valid/ack handshake. Bits arriving while a word is
//   held unacknowledged are dropped and flagged by the sticky o_overrun.
//
// Parameters
//   Width     bits per assembled word (>= 2)
//   MsbFirst  1: first received bit lands in o_parallel_out[Width-1]
//             0: first received bit lands in o_parallel_out[0]
//
// Ports
//   i_clock         single clock, all state updates on the rising edge
//   i_reset_not     synchronous active-low reset
//   i_enable        qualifies i_data as a serial bit this edge
//   i_data          serial bit
//   i_clear         synchronous abort of the current word and of o_overrun
//   i_ack           consumer accepts the held word
//   o_parallel_out  last completed word
//   o_valid         o_parallel_out holds an unacknowledged word
//   o_bit_count     bits collected toward the current word
//   o_overrun       sticky: a bit arrived while a word was held

module serial_word_assembler #(
    parameter int unsigned Width    = 8,
    parameter bit          MsbFirst = 1'b1
) (
    input  logic                     i_clock,
    input  logic                     i_reset_not,
    input  logic                     i_enable,
    input  logic                     i_data,
    input  logic                     i_clear,
    input  logic                     i_ack,
    output logic [Width-1:0]         o_parallel_out,
    output logic                     o_valid,
    output logic [$clog2(Width)-1:0] o_bit_count,
    output logic                     o_overrun
);

    localparam int unsigned CntW = $clog2(Width);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    localparam logic [CntW-1:0] LAST_BIT = CntW'(Width - 1);

    logic [0:0]       r_state;
    logic [Width-1:0] r_shift;
    logic [Width-1:0] r_parallel_out;
    logic [CntW-1:0]  r_bit_count;
    logic             r_overrun;

    logic [0:0]       w_state;
    logic [Width-1:0] w_shift;
    logic [Width-1:0] w_parallel_out;
    logic [CntW-1:0]  w_bit_count;
    logic             w_overrun;
    logic [Width-1:0] w_shift_in;

    // Shift register with the incoming bit merged in. In HOLD the shift
    // register is already zero, so this also forms bit 0 of the next word.
    always_comb begin
        if (MsbFirst) begin
            w_shift_in = {r_shift[Width-2:0], i_data};
        end else begin
            w_shift_in = {i_data, r_shift[Width-1:1]};
        end
    end

    always_comb begin
        w_state        = r_state;
        w_shift        = r_shift;
        w_parallel_out = r_parallel_out;
        w_bit_count    = r_bit_count;
        w_overrun      = r_overrun;

        if (i_clear) begin
            // Abort: parallel output is deliberately kept.
            w_state     = ST_COLLECT;
            w_shift     = '0;
            w_bit_count = '0;
            w_overrun   = 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (i_enable) begin
                        if (r_bit_count == LAST_BIT) begin
                            w_parallel_out = w_shift_in;
                            w_state        = ST_HOLD;
                            w_bit_count    = '0;
                            w_shift        = '0;
                        end else begin
                            w_shift     = w_shift_in;
                            w_bit_count = r_bit_count + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_ack) begin
                        w_state = ST_COLLECT;
                        if (i_enable) begin
                            w_shift     = w_shift_in;
                            w_bit_count = CntW'(1);
                        end
                    end else if (i_enable) begin
                        w_overrun = 1'b1;
                    end
                end
                default: begin
                    w_state = ST_COLLECT;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_not) begin
            r_state        <= ST_COLLECT;
            r_shift        <= '0;
            r_parallel_out <= '0;
            r_bit_count    <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_shift        <= w_shift;
            r_parallel_out <= w_parallel_out;
            r_bit_count    <= w_bit_count;
            r_overrun      <= w_overrun;
        end
    end

    // HOLD is exactly the state in which a word is presented.
    assign o_valid        = (r_state == ST_HOLD);
    assign o_parallel_out = r_parallel_out;
    assign o_bit_count    = r_bit_count;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_serial_word_assembler.sv
module tb_serial_word_assembler;

    logic clk;
    logic rst_n;
    logic en;
    logic d;
    logic clr;
    logic ack;

    logic [7:0] m_out;
    logic       m_valid;
    logic [2:0] m_cnt;
    logic       m_ovr;
    logic [7:0] l_out;
    logic       l_valid;
    logic [2:0] l_cnt;
    logic       l_ovr;

    int n_checks;
    int n_errors;

    serial_word_assembler #(.Width(8), .MsbFirst(1'b1)) u_msb (
        .i_clock        (clk),
        .i_reset_not    (rst_n),
        .i_enable       (en),
        .i_data         (d),
        .i_clear        (clr),
        .i_ack          (ack),
        .o_parallel_out (m_out),
        .o_valid        (m_valid),
        .o_bit_count    (m_cnt),
        .o_overrun      (m_ovr)
    );

    serial_word_assembler #(.Width(8), .MsbFirst(1'b0)) u_lsb (
        .i_clock        (clk),
        .i_reset_not    (rst_n),
        .i_enable       (en),
        .i_data         (d),
        .i_clear        (clr),
        .i_ack          (ack),
        .o_parallel_out (l_out),
        .o_valid        (l_valid),
        .o_bit_count    (l_cnt),
        .o_overrun      (l_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       en;
        logic       d;
        logic       ack;
        logic [7:0] out;
        logic       v;
        logic [2:0] cnt;
        logic       ovr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic r, input logic c, input logic e, input logic b,
                        input logic a);
        rst_n = r;
        clr   = c;
        en    = e;
        d     = b;
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string name, input logic [7:0] mo, input logic [7:0] lo,
                            input logic v, input logic [2:0] c, input logic o);
        chk({name, " msb out"}, 32'(m_out), 32'(mo));
        chk({name, " lsb out"}, 32'(l_out), 32'(lo));
        chk({name, " msb valid"}, 32'(m_valid), 32'(v));
        chk({name, " lsb valid"}, 32'(l_valid), 32'(v));
        chk({name, " msb cnt"}, 32'(m_cnt), 32'(c));
        chk({name, " lsb cnt"}, 32'(l_cnt), 32'(c));
        chk({name, " msb ovr"}, 32'(m_ovr), 32'(o));
        chk({name, " lsb ovr"}, 32'(l_ovr), 32'(o));
    endtask

    task automatic feed(input logic [7:0] bits, input int n);
        // Sends bits[7], bits[6], ... n bits, enable high, no ack.
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b1, bits[7-i], 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        d     = 1'b0;
        ack   = 1'b0;

        // MSB-first word B2 (bits 1,0,1,1,0,0,1,0), overrun, ack, clear.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd5, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd6, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd7, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 3'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 3'd0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 1'b1, 3'd0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 1'b1, 3'd0, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 3'd0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 3'd0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 3'd0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].rst_n, vecs[i].clr, vecs[i].en, vecs[i].d, vecs[i].ack);
            chk($sformatf("vec%0d out", i), 32'(m_out), 32'(vecs[i].out));
            chk($sformatf("vec%0d valid", i), 32'(m_valid), 32'(vecs[i].v));
            chk($sformatf("vec%0d cnt", i), 32'(m_cnt), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d ovr", i), 32'(m_ovr), 32'(vecs[i].ovr));
        end
        // The LSB-first instance saw the same bits: 1,0,1,1,0,0,1,0 -> 4D.
        chk("table lsb out", 32'(l_out), 32'h4D);

        // Simultaneous ack and enable: bit becomes bit 0 of the next word.
        feed(8'hB2, 8);
        chk_both("word before ack", 8'hB2, 8'h4D, 1'b1, 3'd0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_both("ack+enable", 8'hB2, 8'h4D, 1'b0, 3'd1, 1'b0);
        feed(8'h02, 7);  // 0,0,0,0,0,0,1
        chk_both("after ack+enable word", 8'h81, 8'h81, 1'b1, 3'd0, 1'b0);

        // LSB-first with enable gaps: valid only after the 8th enabled bit.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_both("reset", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] pat;
            pat = 8'hB2;
            step(1'b1, 1'b0, 1'b1, pat[7-i], 1'b1);
            if (i == 7) begin
                chk_both("gap word done", 8'hB2, 8'h4D, 1'b1, 3'd0, 1'b0);
            end else begin
                step(1'b1, 1'b0, 1'b0, ~pat[7-i], 1'b1);
                chk($sformatf("gap%0d lsb cnt", i), 32'(l_cnt), 32'(i + 1));
                chk($sformatf("gap%0d lsb valid", i), 32'(l_valid), 32'd0);
            end
        end

        // Reset mid-word discards the partial word.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(8'hFF, 5);
        chk_both("partial 5", 8'hB2, 8'h4D, 1'b0, 3'd5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk_both("reset mid-word", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        feed(8'hF0, 8);
        chk_both("post-reset word", 8'hF0, 8'h0F, 1'b1, 3'd0, 1'b0);

        // Clear on the completion edge wins; output keeps its value.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        feed(8'hAA, 7);
        chk_both("pre clear 7", 8'hF0, 8'h0F, 1'b0, 3'd7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_both("clear on completion", 8'hF0, 8'h0F, 1'b0, 3'd0, 1'b0);

        // Reset on the completion edge wins too.
        feed(8'hAA, 7);
        chk_both("pre reset 7", 8'hF0, 8'h0F, 1'b0, 3'd7, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_both("reset on completion", 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
